// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU types: mult/div opcode encoding, mult/div FSM states, iteration count.
package mips_cpu_pkg;

  localparam int MULDIV_CYCLES = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    WB   = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/mips_cpu_muldiv_ctrl_if.sv
// Pipeline <-> mult/div unit request, stall and HI/LO write-back signals.
interface mips_cpu_muldiv_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mf_req;
  logic        busy;
  logic        stall;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] write_data_hi;
  logic [31:0] write_data_lo;

  modport master (
    output start, op, rs_data, rt_data, mf_req,
    input  busy, stall, hi_we, lo_we, write_data_hi, write_data_lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, mf_req,
    output busy, stall, hi_we, lo_we, write_data_hi, write_data_lo
  );
endinterface

// File: rtl/mips_cpu_muldiv_core.sv
// Iterative mult/div datapath: shift-add multiply, restoring divide, sign fix-up.
// Latency: 32 step cycles plus one fix-up cycle; MTHI/MTLO load in one cycle.
// Backpressure: none here; the controller sequences load/step/fixup.
module mips_cpu_muldiv_core
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        fixup,
  input  logic        mt_hi,
  input  logic        mt_lo,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        last,
  output logic        div_zero,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);

  logic [31:0] opb;
  logic [63:0] acc;
  logic [31:0] rem;
  logic [5:0]  count;
  logic        is_div, neg_res, neg_rem;

  logic        signed_op, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, rem_shift, rem_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = signed_op & rs_data[31];
    b_neg     = signed_op & rt_data[31];
    a_mag     = a_neg ? -rs_data : rs_data;
    b_mag     = b_neg ? -rt_data : rt_data;
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    // Divide keeps the dividend/quotient shifter in acc[31:0].
    rem_shift = {rem, acc[31]};
    rem_diff  = rem_shift - {1'b0, opb};
    prod_fix  = neg_res ? -acc : acc;
    quo_fix   = neg_res ? -acc[31:0] : acc[31:0];
    rem_fix   = neg_rem ? -rem : rem;
  end

  assign last = (count == 6'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opb      <= '0;
      acc      <= '0;
      rem      <= '0;
      count    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_res   <= '0;
      lo_res   <= '0;
    end else begin
      if (load) begin
        opb      <= b_mag;
        acc      <= {32'd0, a_mag};
        rem      <= '0;
        count    <= 6'(MULDIV_CYCLES);
        is_div   <= (op == OP_DIV) || (op == OP_DIVU);
        neg_res  <= a_neg ^ b_neg;
        neg_rem  <= a_neg;
        div_zero <= ((op == OP_DIV) || (op == OP_DIVU)) && (rt_data == 32'd0);
      end else if (step) begin
        count <= count - 6'd1;
        if (is_div) begin
          rem        <= rem_diff[32] ? rem_shift[31:0] : rem_diff[31:0];
          acc[31:0]  <= {acc[30:0], ~rem_diff[32]};
        end else begin
          acc <= {mul_sum, acc[31:1]};
        end
      end
      if (fixup) begin
        if (is_div) {hi_res, lo_res} <= {rem_fix, quo_fix};
        else        {hi_res, lo_res} <= prod_fix;
      end
      if (mt_hi) hi_res <= rs_data;
      if (mt_lo) lo_res <= rs_data;
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv_ctrl.sv
// MIPS HI/LO mult/div controller: FSM, request handshake and registered write strobes.
// Latency: mult/div strobe in cycle 34 after accept; MTHI/MTLO strobe in cycle 1.
// Backpressure: busy ignores start; stall holds the pipeline on start or MFHI/MFLO.
module mips_cpu_muldiv_ctrl
  import mips_cpu_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  mips_cpu_muldiv_ctrl_if.slave         bus
);

  muldiv_state_e state, next_state;
  logic hi_we_d, lo_we_d;
  logic load, step, fixup, mt_hi, mt_lo;
  logic last, div_zero;

  mips_cpu_muldiv_core u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .fixup    (fixup),
    .mt_hi    (mt_hi),
    .mt_lo    (mt_lo),
    .op       (bus.op),
    .rs_data  (bus.rs_data),
    .rt_data  (bus.rt_data),
    .last     (last),
    .div_zero (div_zero),
    .hi_res   (bus.write_data_hi),
    .lo_res   (bus.write_data_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bus.hi_we <= 1'b0;
      bus.lo_we <= 1'b0;
    end else begin
      state     <= next_state;
      bus.hi_we <= hi_we_d;
      bus.lo_we <= lo_we_d;
    end
  end

  always_comb begin
    next_state = state;
    hi_we_d    = 1'b0;
    lo_we_d    = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    fixup      = 1'b0;
    mt_hi      = 1'b0;
    mt_lo      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              load       = 1'b1;
              next_state = CALC;
            end
            OP_MTHI: begin
              mt_hi      = 1'b1;
              hi_we_d    = 1'b1;
              next_state = WB;
            end
            OP_MTLO: begin
              mt_lo      = 1'b1;
              lo_we_d    = 1'b1;
              next_state = WB;
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) next_state = SIGN;
      end
      SIGN: begin
        // Divide by zero runs the full sequence but never writes HI/LO.
        fixup      = 1'b1;
        hi_we_d    = !div_zero;
        lo_we_d    = !div_zero;
        next_state = WB;
      end
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign bus.busy  = (state != IDLE);
  assign bus.stall = bus.busy & (bus.mf_req | bus.start);

endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// Randomized self-checking bench for mips_cpu_muldiv_ctrl against an arithmetic HI/LO model.
module tb_mips_cpu_muldiv_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;

  mips_cpu_muldiv_ctrl_if bus ();

  mips_cpu_muldiv_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected HI/LO writes and timing, from plain 64-bit arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el,
                       output int nh, output int nl, output int strobe_cyc, output int busy_len);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     v, w;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    eh = '0; el = '0; nh = 0; nl = 0; strobe_cyc = 34; busy_len = 34;
    case (o)
      3'd0: begin v = sa * sb; eh = v[63:32]; el = v[31:0]; nh = 1; nl = 1; end
      3'd1: begin v = ua * ub; eh = v[63:32]; el = v[31:0]; nh = 1; nl = 1; end
      3'd2: if (b != 0) begin
        q = sa / sb; r = sa % sb; v = q; w = r;
        el = v[31:0]; eh = w[31:0]; nh = 1; nl = 1;
      end
      3'd3: if (b != 0) begin
        v = ua / ub; w = ua % ub;
        el = v[31:0]; eh = w[31:0]; nh = 1; nl = 1;
      end
      3'd4: begin eh = a; nh = 1; strobe_cyc = 1; busy_len = 1; end
      3'd5: begin el = a; nl = 1; strobe_cyc = 1; busy_len = 1; end
      default: begin strobe_cyc = 0; busy_len = 0; end
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el, hv, lv;
    int nh, nl, scyc, blen, hc, lc, hcyc, lcyc, done, cyc;
    bit inj;
    model(o, a, b, eh, el, nh, nl, scyc, blen);
    hc = 0; lc = 0; hcyc = 0; lcyc = 0; done = 0; hv = '0; lv = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rs_data = a; bus.rt_data = b; bus.mf_req = 1'b0;
    @(posedge clk);
    cyc = 1;
    while (done == 0 && cyc <= 60) begin
      @(negedge clk);
      // A second request mid-operation must be ignored and only stall.
      inj = (cyc == 5) && (blen >= 6);
      bus.start = inj;
      if (inj) begin bus.op = 3'd5; bus.rs_data = $urandom; end
      bus.mf_req = 1'($urandom_range(0, 1));
      #1;
      chk("busy", bus.busy, cyc <= blen);
      chk("stall", bus.stall, (cyc <= blen) && (bus.mf_req || bus.start));
      if (bus.hi_we) begin hc++; hcyc = cyc; hv = bus.write_data_hi; end
      if (bus.lo_we) begin lc++; lcyc = cyc; lv = bus.write_data_lo; end
      if (!bus.busy) done = cyc;
      cyc++;
    end
    bus.start = 1'b0;
    bus.mf_req = 1'b0;
    chk("idle_cycle", done, blen + 1);
    chk("hi_we_count", hc, nh);
    chk("lo_we_count", lc, nl);
    if (nh > 0) begin chk("hi_cycle", hcyc, scyc); chk("hi_data", hv, eh); end
    if (nl > 0) begin chk("lo_cycle", lcyc, scyc); chk("lo_data", lv, el); end
  endtask

  task automatic reset_mid_div();
    int strobes;
    strobes = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.rs_data = 32'd1000; bus.rt_data = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (bus.hi_we || bus.lo_we) strobes++;
    end
    reset = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_hi_we", bus.hi_we, 1'b0);
    chk("rst_lo_we", bus.lo_we, 1'b0);
    chk("rst_wd_hi", bus.write_data_hi, 32'd0);
    chk("rst_wd_lo", bus.write_data_lo, 32'd0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 3) reset = 1'b1;
      #1;
      if (bus.hi_we || bus.lo_we) strobes++;
    end
    chk("rst_abort_strobes", strobes, 0);
    chk("rst_abort_idle", bus.busy, 1'b0);
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    n_checks = 0;
    n_err = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.rs_data = '0; bus.rt_data = '0; bus.mf_req = 1'b0;
    #12;
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_hi_we", bus.hi_we, 1'b0);
    chk("reset_lo_we", bus.lo_we, 1'b0);
    chk("reset_wd_hi", bus.write_data_hi, 32'd0);
    chk("reset_wd_lo", bus.write_data_lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd3, 32'd5, 32'd0);
    run_op(3'd5, 32'h1234_5678, 32'd0);
    run_op(3'd4, 32'hCAFE_F00D, 32'd0);
    run_op(3'd6, 32'h1111_1111, 32'd3);
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE);

    reset_mid_div();
    run_op(3'd0, 32'd123456, 32'hFFFF_FF00);

    for (int i = 0; i < 25; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 300));
      run_op(o, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
